id_ex_register: RTL and testbench
=================================

// Module: id_ex_register
// PURPOSE
//  Producer side of the 160-bit ID/EX pipeline word that the EX-stage decoder consumes.
//  - Captures the decoded ID-stage instruction and its operands each clock.
//  - Detects load-use hazards and inserts a one-cycle bubble.
//  - Handles EX back-pressure by holding, and flushes on redirect.
//  - Drives stall_o back to PC/IF-ID and counts inserted bubbles for perf analysis.
// PARAMETERS
//  CNT_W    16     width of saturating bubble counter
//  NOP_WORD 32'h0  instruction slot value for a bubble (sll $0,$0,0)
// PORTS
//  clk            in   1    single clock, rising edge
//  rst            in   1    asynchronous, active-high reset
//  id_valid_i     in   1    ID stage holds a real instruction
//  id_instr_i     in   32   raw instruction
//  id_pc4_i       in   32   PC+4 of instruction
//  id_rs_data_i   in   32   register-file read port A (rs)
//  id_rt_data_i   in   32   register-file read port B (rt)
//  id_ext_imm_i   in   32   sign/zero-extended immediate
//  ex_stall_i     in   1    EX cannot accept (multi-cycle op); hold
//  flush_i        in   1    branch/jump redirect; kill ID->EX transfer
//  idex_reg_o     out  160  {ext_imm[159:128], rt_data[127:96], rs_data[95:64], pc4[63:32], instr[31:0]}
//  idex_valid_o   out  1    idex_reg_o holds a real instruction
//  stall_o        out  1    freeze PC and IF/ID this cycle
//  bubble_cnt_o   out  CNT_W  saturating count of hazard bubbles inserted
// BEHAVIOUR
//  Reset (async, any time incl. mid-stall):
//   - idex_reg_o=0 (instr=NOP_WORD), idex_valid_o=0, bubble_cnt_o=0; stall_o=0 while rst high.
//  Hazard (combinational):
//   - load_in_ex = idex_valid_o & op(idex[31:26]) in {100011 lw, 100000 lb, 100100 lbu}.
//   - ld_rt = idex[20:16]; hazard requires ld_rt!=0.
//   - uses_rs: all ops except J/JAL/LUI and R-type shifts sll/srl/sra.
//   - uses_rt: R-type, beq/bne, sw/sb.
//   - hazard = id_valid_i & load_in_ex & ld_rt!=0 & ((uses_rs & rs==ld_rt) | (uses_rt & rt==ld_rt)).
//  stall_o = ex_stall_i | (hazard & ~flush_i); combinational, no register.
//  Update priority per rising edge (highest first):
//   1. flush_i: load bubble (instr=NOP_WORD, other fields 0, valid=0). Overrides ex_stall_i; no count.
//   2. ex_stall_i: hold idex_reg_o/idex_valid_o unchanged. Hazard is not bubbled this cycle;
//      it re-evaluates next cycle.
//   3. hazard: load bubble, bubble_cnt_o+=1 (saturate at all-ones).
//   4. else: load inputs; idex_valid_o=id_valid_i; if !id_valid_i load bubble instead (no count).
//  Latency:
//   - 1 cycle ID->EX.
//   - Hazard costs exactly 1 bubble: after it, EX holds a NOP, so load_in_ex=0 and the dependent
//     instruction proceeds next edge.
//  Boundaries:
//   - load with rt=$0: never a hazard.
//   - Back-to-back loads with a dependent chain: one bubble per dependency.
//   - Counter at max stays at max.
//   - Flush and hazard together: flush only, stall_o=0.
// STRUCTURE
//  Shared package mips_pkg:
//   - opcode/funct localparams (OP_RTYPE, OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB, OP_BEQ, OP_BNE,
//     OP_J, OP_JAL, OP_LUI, FN_SLL, FN_SRL, FN_SRA).
//   - IDEX field offsets (IDEX_INSTR_LSB=0, IDEX_PC4_LSB=32, IDEX_RS_LSB=64, IDEX_RT_LSB=96,
//     IDEX_IMM_LSB=128), IDEX_W=160.
//  One sub-module: load_use_detect (pure combinational; inputs idex instr+valid, id instr+valid;
//  output hazard). Pipeline register, priority mux and counter stay in this module.
// TESTING
//  1. rst=1 mid-operation with valid word held -> same cycle idex_reg_o=0, idex_valid_o=0,
//     bubble_cnt_o=0, stall_o=0.
//  2. lw $t0,0($s0) then add $t1,$t0,$t2 -> stall_o=1 one cycle; one NOP with valid=0 between;
//     add reaches EX next edge; bubble_cnt_o=1.
//  3. lw $0,0($s0) then add $t1,$0,$t2 -> no stall; lw $t0 then sll $t1,$t0,2 (rs unused) -> no stall.
//  4. Hazard pending with ex_stall_i=1 for 3 cycles -> idex held, stall_o=1 each cycle, no count;
//     ex_stall_i drops -> one bubble, count+1.
//  5. flush_i with hazard and ex_stall_i both high -> bubble loaded, stall_o=0, count unchanged.
//  6. Preload counter near max via 2^CNT_W-1 hazards (CNT_W=4 build) -> saturates at 4'hF on
//     the 16th hazard.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and ID/EX pipeline-word field layout.
// Latency: none (constants and a pure helper only).
// Backpressure: not applicable.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0]) for shifts that take their source from rt only
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;

    // ID/EX word layout: {ext_imm, rt_data, rs_data, pc4, instr}
    localparam int unsigned IDEX_INSTR_LSB = 0;
    localparam int unsigned IDEX_PC4_LSB   = 32;
    localparam int unsigned IDEX_RS_LSB    = 64;
    localparam int unsigned IDEX_RT_LSB    = 96;
    localparam int unsigned IDEX_IMM_LSB   = 128;
    localparam int unsigned IDEX_W         = 160;

    // Loads whose result is only available after EX/MEM, hence the bubble
    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// ID->EX handshake bundle: ID-stage instruction/operands and control in, ID/EX word and status out.
// Latency: none (wires only); master = ID/control side, slave = the ID/EX register.
// Backpressure: ex_stall_i holds the register; stall_o tells PC and IF/ID to freeze.
interface id_ex_register_if #(
    parameter int CNT_W = 16
) ();

    logic                        id_valid_i;
    logic [31:0]                 id_instr_i;
    logic [31:0]                 id_pc4_i;
    logic [31:0]                 id_rs_data_i;
    logic [31:0]                 id_rt_data_i;
    logic [31:0]                 id_ext_imm_i;
    logic                        ex_stall_i;
    logic                        flush_i;
    logic [mips_pkg::IDEX_W-1:0] idex_reg_o;
    logic                        idex_valid_o;
    logic                        stall_o;
    logic [CNT_W-1:0]            bubble_cnt_o;

    modport master (
        output id_valid_i, id_instr_i, id_pc4_i, id_rs_data_i, id_rt_data_i, id_ext_imm_i,
        output ex_stall_i, flush_i,
        input  idex_reg_o, idex_valid_o, stall_o, bubble_cnt_o
    );

    modport slave (
        input  id_valid_i, id_instr_i, id_pc4_i, id_rs_data_i, id_rt_data_i, id_ext_imm_i,
        input  ex_stall_i, flush_i,
        output idex_reg_o, idex_valid_o, stall_o, bubble_cnt_o
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose rt is read by the instruction in ID.
// Latency: purely combinational. Ports: idex instr/valid (EX side), id instr/valid, hazard_o.
// Backpressure: none; the caller decides whether the hazard turns into a bubble.
module load_use_detect
    import mips_pkg::*;
(
    input  logic [31:0] idex_instr_i,
    input  logic        idex_valid_i,
    input  logic [31:0] id_instr_i,
    input  logic        id_valid_i,
    output logic        hazard_o
);

    logic [5:0] ex_op;
    logic [4:0] ld_rt;
    logic [5:0] id_op;
    logic [5:0] id_fn;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       load_in_ex;
    logic       id_shift;
    logic       uses_rs;
    logic       uses_rt;
    logic       unused_ok;

    assign ex_op = idex_instr_i[31:26];
    assign ld_rt = idex_instr_i[20:16];
    assign id_op = id_instr_i[31:26];
    assign id_fn = id_instr_i[5:0];
    assign id_rs = id_instr_i[25:21];
    assign id_rt = id_instr_i[20:16];

    assign unused_ok = ^{idex_instr_i[25:21], idex_instr_i[15:0], id_instr_i[15:6]};

    assign load_in_ex = idex_valid_i & is_load(ex_op);

    // Constant shifts carry their source in rt; the rs field is ignored by the datapath.
    assign id_shift = (id_op == OP_RTYPE) &&
                      ((id_fn == FN_SLL) || (id_fn == FN_SRL) || (id_fn == FN_SRA));

    assign uses_rs = !((id_op == OP_J) || (id_op == OP_JAL) || (id_op == OP_LUI) || id_shift);

    assign uses_rt = (id_op == OP_RTYPE) || (id_op == OP_BEQ) || (id_op == OP_BNE) ||
                     (id_op == OP_SW)    || (id_op == OP_SB);

    // $0 is hardwired zero, so a load targeting it never produces a dependency.
    assign hazard_o = id_valid_i & load_in_ex & (ld_rt != 5'd0) &
                      ((uses_rs & (id_rs == ld_rt)) | (uses_rt & (id_rt == ld_rt)));

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush, and a saturating bubble counter.
// Latency: 1 cycle ID->EX; a load-use hazard costs exactly one bubble. Ports: clk, rst, bus (slave).
// Backpressure: ex_stall_i holds the word; stall_o freezes PC and IF/ID, forced low on flush/reset.
module id_ex_register
    import mips_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    id_ex_register_if.slave bus
);

    logic [IDEX_W-1:0] bubble_word;
    logic [IDEX_W-1:0] idex_d;
    logic [IDEX_W-1:0] idex_q;
    logic              valid_d;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              hazard;

    assign bubble_word = {{(IDEX_W-32){1'b0}}, NOP_WORD};

    load_use_detect u_load_use_detect (
        .idex_instr_i (idex_q[IDEX_INSTR_LSB +: 32]),
        .idex_valid_i (valid_q),
        .id_instr_i   (bus.id_instr_i),
        .id_valid_i   (bus.id_valid_i),
        .hazard_o     (hazard)
    );

    // Update priority: flush > EX hold > hazard bubble > normal load.
    always_comb begin
        idex_d  = idex_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (bus.flush_i) begin
            idex_d  = bubble_word;
            valid_d = 1'b0;
        end else if (bus.ex_stall_i) begin
            // Hold; a pending hazard is re-evaluated once EX releases.
            idex_d  = idex_q;
            valid_d = valid_q;
        end else if (hazard) begin
            idex_d  = bubble_word;
            valid_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (bus.id_valid_i) begin
            idex_d  = {bus.id_ext_imm_i, bus.id_rt_data_i, bus.id_rs_data_i,
                       bus.id_pc4_i, bus.id_instr_i};
            valid_d = 1'b1;
        end else begin
            idex_d  = bubble_word;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= bubble_word;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.idex_reg_o   = idex_q;
    assign bus.idex_valid_o = valid_q;
    assign bus.bubble_cnt_o = cnt_q;

    // A redirect must reach the PC, so flush drops the freeze even while EX is busy.
    assign bus.stall_o = ~rst & ~bus.flush_i & (bus.ex_stall_i | hazard);

endmodule

// File: tb/tb_id_ex_register.sv
module tb_id_ex_register;

    localparam int CNT_W = 4;

    localparam logic [31:0] LW_T0    = 32'h8E08_0000; // lw  $t0,0($s0)
    localparam logic [31:0] LW_ZERO  = 32'h8E00_0000; // lw  $0,0($s0)
    localparam logic [31:0] LW_T1_T0 = 32'h8D09_0000; // lw  $t1,0($t0)
    localparam logic [31:0] ADD_T0   = 32'h010A_4820; // add $t1,$t0,$t2
    localparam logic [31:0] ADD_ZERO = 32'h000A_4820; // add $t1,$0,$t2
    localparam logic [31:0] ADD_T1   = 32'h0129_5020; // add $t2,$t1,$t1
    localparam logic [31:0] SLL_X    = 32'h010A_4880; // sll $t1,$t2,2 with $t0 in the ignored rs field
    localparam logic [159:0] BUB     = 160'h0;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [CNT_W-1:0] exp_cnt;

    id_ex_register_if #(.CNT_W(CNT_W)) bus ();

    id_ex_register #(.CNT_W(CNT_W), .NOP_WORD(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [159:0] word(input logic [31:0] ins, input logic [31:0] pc4);
        return {{16'h0F0F, pc4[15:0]}, {16'h5A5A, pc4[15:0]}, {16'hA5A5, pc4[15:0]}, pc4, ins};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc4);
        logic [159:0] w;
        w = word(ins, pc4);
        bus.id_valid_i   = v;
        bus.id_instr_i   = w[31:0];
        bus.id_pc4_i     = w[63:32];
        bus.id_rs_data_i = w[95:64];
        bus.id_rt_data_i = w[127:96];
        bus.id_ext_imm_i = w[159:128];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.ex_stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drv(1'b0, 32'h0, 32'h0);
        repeat (2) tick;
        chk("rst_idex", bus.idex_reg_o, BUB);
        chk("rst_valid", bus.idex_valid_o, 1'b0);
        chk("rst_cnt", bus.bubble_cnt_o, 0);
        chk("rst_stall", bus.stall_o, 1'b0);
        rst = 1'b0;
        exp_cnt = '0;

        // Basic load-use: lw $t0 then add reading $t0
        drv(1'b1, LW_T0, 32'h104);
        tick;
        chk("lw_word", bus.idex_reg_o, word(LW_T0, 32'h104));
        chk("lw_valid", bus.idex_valid_o, 1'b1);
        drv(1'b1, ADD_T0, 32'h108);
        #1 chk("lu_stall", bus.stall_o, 1'b1);
        tick;
        exp_cnt = sat_inc(exp_cnt);
        chk("lu_bubble", bus.idex_reg_o, BUB);
        chk("lu_bub_valid", bus.idex_valid_o, 1'b0);
        chk("lu_cnt", bus.bubble_cnt_o, exp_cnt);
        chk("lu_unstall", bus.stall_o, 1'b0);
        tick;
        chk("lu_add_word", bus.idex_reg_o, word(ADD_T0, 32'h108));
        chk("lu_add_valid", bus.idex_valid_o, 1'b1);

        // Asynchronous reset mid-operation while EX is stalling
        bus.ex_stall_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_idex", bus.idex_reg_o, BUB);
        chk("arst_valid", bus.idex_valid_o, 1'b0);
        chk("arst_cnt", bus.bubble_cnt_o, 0);
        chk("arst_stall", bus.stall_o, 1'b0);
        #3;
        rst = 1'b0;
        bus.ex_stall_i = 1'b0;
        exp_cnt = '0;

        // Load into $0 is never a hazard
        drv(1'b1, LW_ZERO, 32'h200);
        tick;
        drv(1'b1, ADD_ZERO, 32'h204);
        #1 chk("z_stall", bus.stall_o, 1'b0);
        tick;
        chk("z_add_word", bus.idex_reg_o, word(ADD_ZERO, 32'h204));
        // Shift ignores its rs field even when it names the loaded register
        drv(1'b1, LW_T0, 32'h208);
        tick;
        drv(1'b1, SLL_X, 32'h20C);
        #1 chk("sll_stall", bus.stall_o, 1'b0);
        tick;
        chk("sll_word", bus.idex_reg_o, word(SLL_X, 32'h20C));
        // Invalid ID slot loads a bubble without counting
        drv(1'b0, ADD_T0, 32'h210);
        tick;
        chk("inv_bubble", bus.idex_reg_o, BUB);
        chk("inv_valid", bus.idex_valid_o, 1'b0);
        chk("inv_cnt", bus.bubble_cnt_o, exp_cnt);

        // Dependent chain of loads: one bubble per dependency
        drv(1'b1, LW_T0, 32'h300);
        tick;
        drv(1'b1, LW_T1_T0, 32'h304);
        #1 chk("ch1_stall", bus.stall_o, 1'b1);
        tick;
        exp_cnt = sat_inc(exp_cnt);
        chk("ch1_bubble", bus.idex_reg_o, BUB);
        chk("ch1_cnt", bus.bubble_cnt_o, exp_cnt);
        tick;
        chk("ch1_lw_word", bus.idex_reg_o, word(LW_T1_T0, 32'h304));
        drv(1'b1, ADD_T1, 32'h308);
        #1 chk("ch2_stall", bus.stall_o, 1'b1);
        tick;
        exp_cnt = sat_inc(exp_cnt);
        chk("ch2_bubble", bus.idex_reg_o, BUB);
        chk("ch2_cnt", bus.bubble_cnt_o, exp_cnt);
        tick;
        chk("ch2_add_word", bus.idex_reg_o, word(ADD_T1, 32'h308));

        // Pending hazard under EX stall: hold, no count, then exactly one bubble
        drv(1'b1, LW_T0, 32'h400);
        tick;
        drv(1'b1, ADD_T0, 32'h404);
        bus.ex_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", bus.stall_o, 1'b1);
            tick;
            chk("hold_word", bus.idex_reg_o, word(LW_T0, 32'h400));
            chk("hold_cnt", bus.bubble_cnt_o, exp_cnt);
        end
        bus.ex_stall_i = 1'b0;
        #1 chk("rel_stall", bus.stall_o, 1'b1);
        tick;
        exp_cnt = sat_inc(exp_cnt);
        chk("rel_bubble", bus.idex_reg_o, BUB);
        chk("rel_cnt", bus.bubble_cnt_o, exp_cnt);
        tick;
        chk("rel_add_word", bus.idex_reg_o, word(ADD_T0, 32'h404));

        // Flush with hazard and EX stall together
        drv(1'b1, LW_T0, 32'h500);
        tick;
        drv(1'b1, ADD_T0, 32'h504);
        bus.ex_stall_i = 1'b1;
        bus.flush_i = 1'b1;
        #1 chk("fl_stall", bus.stall_o, 1'b0);
        tick;
        chk("fl_bubble", bus.idex_reg_o, BUB);
        chk("fl_valid", bus.idex_valid_o, 1'b0);
        chk("fl_cnt", bus.bubble_cnt_o, exp_cnt);
        bus.ex_stall_i = 1'b0;
        bus.flush_i = 1'b0;
        // Flush with hazard only
        drv(1'b1, LW_T0, 32'h508);
        tick;
        drv(1'b1, ADD_T0, 32'h50C);
        bus.flush_i = 1'b1;
        #1 chk("fl2_stall", bus.stall_o, 1'b0);
        tick;
        chk("fl2_bubble", bus.idex_reg_o, BUB);
        chk("fl2_cnt", bus.bubble_cnt_o, exp_cnt);
        bus.flush_i = 1'b0;

        // Drive the counter to saturation and beyond
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, LW_T0, 32'h600);
            tick;
            drv(1'b1, ADD_T0, 32'h604);
            tick;
            exp_cnt = sat_inc(exp_cnt);
            chk("sat_step", bus.bubble_cnt_o, exp_cnt);
        end
        chk("sat_max", bus.bubble_cnt_o, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
